// File: rtl/ex_result_pipe_if.sv
// Bundle of the issue, control, lookup, forwarding and writeback signals of
// one ex_result_pipe instance.  The pipe sits on the slave modport; the
// issuing stage / decode logic sits on the master modport.
// Optional feature macro: EX_RESULT_PERF_EN (adds perf_issued / perf_wb).
interface ex_result_pipe_if #(
   parameter int DEPTH  = 7,
   parameter int DATA_W = 128,
   parameter int REG_W  = 7,
   parameter int LAT_W  = 3
);
   // Control and issue. There is no backpressure: an issue is accepted
   // whenever in_valid is high on an edge with stall and flush both low.
   logic                    stall;
   logic                    flush;
   logic                    in_valid;
   logic                    in_regWriteEnable;
   logic [REG_W-1:0]        in_rt;
   logic [DATA_W-1:0]       in_result;
   logic [LAT_W-1:0]        in_latency;
   // Lookup port
   logic [REG_W-1:0]        q_rt;
   logic                    q_hit_pending;
   logic                    q_hit_ready;
   logic [DATA_W-1:0]       q_data;
   // Forwarding taps, stage 0 in the LSBs
   logic [DEPTH-1:0]        fwd_valid;
   logic [DEPTH*REG_W-1:0]  fwd_rt;
   logic [DEPTH*DATA_W-1:0] fwd_data;
   // Writeback
   logic                    wb_en;
   logic [REG_W-1:0]        wb_rt;
   logic [DATA_W-1:0]       wb_data;
`ifdef EX_RESULT_PERF_EN
   logic [31:0]             perf_issued;
   logic [31:0]             perf_wb;
`endif

   modport master (
      output stall, flush, in_valid, in_regWriteEnable, in_rt, in_result,
             in_latency, q_rt,
      input  q_hit_pending, q_hit_ready, q_data, fwd_valid, fwd_rt, fwd_data,
             wb_en, wb_rt, wb_data
`ifdef EX_RESULT_PERF_EN
      , input perf_issued, perf_wb
`endif
   );

   modport slave (
      input  stall, flush, in_valid, in_regWriteEnable, in_rt, in_result,
             in_latency, q_rt,
      output q_hit_pending, q_hit_ready, q_data, fwd_valid, fwd_rt, fwd_data,
             wb_en, wb_rt, wb_data
`ifdef EX_RESULT_PERF_EN
      , output perf_issued, perf_wb
`endif
   );
endinterface

// File: rtl/ex_result_pipe.sv
// Per-slot EX result staging pipeline.  Each issued result walks a
// DEPTH-stage shift register, counting down its unit latency; every stage
// is a forwarding tap, a lookup port finds the youngest match for decode,
// and the last stage drives register-file writeback.
// Optional feature macro: EX_RESULT_PERF_EN adds issue / writeback counters.
module ex_result_pipe #(
   parameter int DEPTH        = 7,
   parameter int DATA_W       = 128,
   parameter int REG_W        = 7,
   parameter int LAT_W        = 3,
   parameter int FLUSH_STAGES = 2
) (
   input logic              clk,
   input logic              reset,
   ex_result_pipe_if.slave  bus
);

   localparam logic [LAT_W:0] DEPTH_EXT = (LAT_W+1)'(DEPTH);

   logic              valid_q [DEPTH];
   logic              we_q    [DEPTH];
   logic [REG_W-1:0]  rt_q    [DEPTH];
   logic [DATA_W-1:0] data_q  [DEPTH];
   logic [LAT_W-1:0]  cnt_q   [DEPTH];

   logic              valid_d [DEPTH];
   logic              we_d    [DEPTH];
   logic [REG_W-1:0]  rt_d    [DEPTH];
   logic [DATA_W-1:0] data_d  [DEPTH];
   logic [LAT_W-1:0]  cnt_d   [DEPTH];

   logic [LAT_W-1:0]  lat_eff;
   logic [LAT_W:0]    lat_ext;

   // Clamp the issued latency into 1..DEPTH so the countdown always ends
   // inside the pipe.
   always_comb begin
      lat_ext = {1'b0, bus.in_latency};
      lat_eff = bus.in_latency;
      if (bus.in_latency == '0)
         lat_eff = LAT_W'(1);
      else if (lat_ext > DEPTH_EXT)
         lat_eff = LAT_W'(DEPTH);
   end

   // Next-state: hold on stall, otherwise shift with a saturating
   // countdown; flush then clears the youngest stages in either case.
   always_comb begin
      for (int s = 0; s < DEPTH; s++) begin
         valid_d[s] = valid_q[s];
         we_d[s]    = we_q[s];
         rt_d[s]    = rt_q[s];
         data_d[s]  = data_q[s];
         cnt_d[s]   = cnt_q[s];
      end
      if (!bus.stall) begin
         valid_d[0] = bus.in_valid;
         we_d[0]    = bus.in_valid & bus.in_regWriteEnable;
         rt_d[0]    = bus.in_valid ? bus.in_rt : '0;
         data_d[0]  = bus.in_valid ? bus.in_result : '0;
         cnt_d[0]   = bus.in_valid ? (lat_eff - LAT_W'(1)) : '0;
         for (int s = 1; s < DEPTH; s++) begin
            valid_d[s] = valid_q[s-1];
            we_d[s]    = we_q[s-1];
            rt_d[s]    = rt_q[s-1];
            data_d[s]  = data_q[s-1];
            cnt_d[s]   = (cnt_q[s-1] == '0) ? '0 : (cnt_q[s-1] - LAT_W'(1));
         end
      end
      if (bus.flush) begin
         for (int s = 0; s < DEPTH; s++) begin
            if (s < FLUSH_STAGES) begin
               valid_d[s] = 1'b0;
               we_d[s]    = 1'b0;
               rt_d[s]    = '0;
               data_d[s]  = '0;
               cnt_d[s]   = '0;
            end
         end
      end
   end

   // Stage registers; reset clears every field of every stage.
   always_ff @(posedge clk) begin
      for (int s = 0; s < DEPTH; s++) begin
         if (reset) begin
            valid_q[s] <= 1'b0;
            we_q[s]    <= 1'b0;
            rt_q[s]    <= '0;
            data_q[s]  <= '0;
            cnt_q[s]   <= '0;
         end else begin
            valid_q[s] <= valid_d[s];
            we_q[s]    <= we_d[s];
            rt_q[s]    <= rt_d[s];
            data_q[s]  <= data_d[s];
            cnt_q[s]   <= cnt_d[s];
         end
      end
   end

   // Forwarding taps and writeback straight from the stage registers.
   always_comb begin
      for (int s = 0; s < DEPTH; s++) begin
         bus.fwd_valid[s]                  = valid_q[s] & we_q[s] & (cnt_q[s] == '0);
         bus.fwd_rt[s*REG_W +: REG_W]      = rt_q[s];
         bus.fwd_data[s*DATA_W +: DATA_W]  = data_q[s];
      end
      bus.wb_en   = valid_q[DEPTH-1] & we_q[DEPTH-1];
      bus.wb_rt   = rt_q[DEPTH-1];
      bus.wb_data = data_q[DEPTH-1];
   end

   logic              hit;
   logic              hit_ready;
   logic [DATA_W-1:0] hit_data;

   // Lookup: scan oldest to youngest so the youngest match overwrites;
   // the youngest match alone decides pending vs. ready.
   always_comb begin
      hit       = 1'b0;
      hit_ready = 1'b0;
      hit_data  = '0;
      for (int s = DEPTH-1; s >= 0; s--) begin
         if (valid_q[s] && we_q[s] && (rt_q[s] == bus.q_rt)) begin
            hit       = 1'b1;
            hit_ready = (cnt_q[s] == '0);
            hit_data  = data_q[s];
         end
      end
      bus.q_hit_pending = hit & ~hit_ready;
      bus.q_hit_ready   = hit_ready;
      bus.q_data        = hit_ready ? hit_data : '0;
   end

`ifdef EX_RESULT_PERF_EN
   logic [31:0] perf_issued_q;
   logic [31:0] perf_wb_q;

   // Free-running wrap-around counters of accepted issues and writeback cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_issued_q <= '0;
         perf_wb_q     <= '0;
      end else begin
         if (bus.in_valid && !bus.stall && !bus.flush)
            perf_issued_q <= perf_issued_q + 32'd1;
         if (bus.wb_en)
            perf_wb_q <= perf_wb_q + 32'd1;
      end
   end

   assign bus.perf_issued = perf_issued_q;
   assign bus.perf_wb     = perf_wb_q;
`endif

endmodule

// File: tb/tb_ex_result_pipe.sv
// Directed bench for ex_result_pipe.  Issued writing results push their
// expected writeback {due cycle, rt, data} into a queue; a negedge monitor
// pops and compares on every wb_en.  Taps and lookup are checked inline.
module tb_ex_result_pipe;

   localparam int DEPTH  = 7;
   localparam int DATA_W = 128;
   localparam int REG_W  = 7;
   localparam int LAT_W  = 3;
   localparam int EW     = 32 + REG_W + DATA_W;

   logic clk;
   logic reset;
   int   cyc;
   int   n_cmp;
   int   n_err;

   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] mon_e;

   ex_result_pipe_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W), .LAT_W(LAT_W)) bus ();

   ex_result_pipe #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W), .LAT_W(LAT_W),
                    .FLUSH_STAGES(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // clock / cycle counter
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_q(input logic [REG_W-1:0] rt);
      bus.q_rt = rt;
      #1;
   endtask

   // Present one issue slot; queue the writeback if it will be accepted.
   task automatic drive(input logic v, input logic we, input logic [REG_W-1:0] rt,
                        input logic [DATA_W-1:0] d, input logic [LAT_W-1:0] lat,
                        input int extra, input bit exp_wb);
      bus.in_valid          = v;
      bus.in_regWriteEnable = we;
      bus.in_rt             = rt;
      bus.in_result         = d;
      bus.in_latency        = lat;
      if (v && we && exp_wb && !bus.stall && !bus.flush)
         exp_q.push_back({32'(cyc + 7 + extra), rt, d});
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, '0, '0, '0, 0, 1'b0);
   endtask

   task automatic drain();
      idle();
      repeat (9) tick();
   endtask

   // writeback monitor
   always @(negedge clk) begin : mon
      if (bus.wb_en) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL wb_unexpected: got rt %0d at cycle %0d, expected no writeback",
                     bus.wb_rt, cyc);
         end else begin
            mon_e = exp_q.pop_front();
            check("wb_cycle", 128'(cyc), 128'(mon_e[EW-1 -: 32]));
            check("wb_rt", 128'(bus.wb_rt), 128'(mon_e[DATA_W +: REG_W]));
            check("wb_data", bus.wb_data, mon_e[DATA_W-1:0]);
         end
      end
   end

   initial begin
      cyc   = 0;
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      bus.q_rt  = '0;
      idle();
      tick();
      tick();
      check("rst_wb_en", 128'(bus.wb_en), 0);
      check("rst_fwd_valid", 128'(bus.fwd_valid), 0);
      check("rst_q_pending", 128'(bus.q_hit_pending), 0);
      check("rst_q_ready", 128'(bus.q_hit_ready), 0);
      check("rst_fwd_rt", 128'(|bus.fwd_rt), 0);
      check("rst_fwd_data", 128'(|bus.fwd_data), 0);
      reset = 1'b0;
      tick();

      // basic latency: rt=5, latency 2
      set_q(7'd5);
      drive(1'b1, 1'b1, 7'd5, {16{8'hA5}}, 3'd2, 0, 1'b1);
      tick();
      idle();
      check("t1_e1_fwd_valid", 128'(bus.fwd_valid), 0);
      check("t1_e1_pending", 128'(bus.q_hit_pending), 1);
      tick();
      check("t1_e2_fwd_valid", 128'(bus.fwd_valid), 128'h02);
      check("t1_e2_fwd_rt1", 128'(bus.fwd_rt[13:7]), 5);
      check("t1_e2_fwd_data1", bus.fwd_data[255:128], {16{8'hA5}});
      check("t1_e2_q_data", bus.q_data, {16{8'hA5}});
      repeat (4) tick();
      check("t1_e6_fwd_valid", 128'(bus.fwd_valid), 128'h20);
      tick();
      check("t1_e7_wb_en", 128'(bus.wb_en), 1);
      check("t1_e7_wb_rt", 128'(bus.wb_rt), 5);
      tick();
      check("t1_e8_wb_en", 128'(bus.wb_en), 0);
      drain();

      // pending lookup: rt=9, latency 6
      set_q(7'd9);
      drive(1'b1, 1'b1, 7'd9, 128'h1234_5678, 3'd6, 0, 1'b1);
      tick();
      idle();
      for (int k = 1; k <= 5; k++) begin
         check("t2_pending", 128'(bus.q_hit_pending), 1);
         check("t2_not_ready", 128'(bus.q_hit_ready), 0);
         tick();
      end
      check("t2_e6_ready", 128'(bus.q_hit_ready), 1);
      check("t2_e6_pending", 128'(bus.q_hit_pending), 0);
      check("t2_e6_q_data", bus.q_data, 128'h1234_5678);
      drain();

      // youngest wins
      set_q(7'd3);
      drive(1'b1, 1'b1, 7'd3, 128'h11, 3'd1, 0, 1'b1);
      tick();
      check("t3_e1_ready", 128'(bus.q_hit_ready), 1);
      check("t3_e1_q_data", bus.q_data, 128'h11);
      drive(1'b1, 1'b1, 7'd3, 128'h22, 3'd4, 0, 1'b1);
      tick();
      idle();
      for (int k = 2; k <= 4; k++) begin
         check("t3_young_pending", 128'(bus.q_hit_pending), 1);
         check("t3_young_not_ready", 128'(bus.q_hit_ready), 0);
         check("t3_young_q_data", bus.q_data, 0);
         tick();
      end
      check("t3_e5_ready", 128'(bus.q_hit_ready), 1);
      check("t3_e5_q_data", bus.q_data, 128'h22);
      drain();

      // stall mid-flight: latency 3, three stalled cycles, issues dropped
      set_q(7'd12);
      drive(1'b1, 1'b1, 7'd12, 128'hBEEF, 3'd3, 3, 1'b1);
      tick();
      bus.stall = 1'b1;
      drive(1'b1, 1'b1, 7'd77, 128'h77, 3'd1, 0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("t4_stall_rt0", 128'(bus.fwd_rt[6:0]), 12);
         check("t4_stall_pending", 128'(bus.q_hit_pending), 1);
         check("t4_stall_fwd_valid", 128'(bus.fwd_valid), 0);
      end
      bus.stall = 1'b0;
      idle();
      tick();
      check("t4_e5_pending", 128'(bus.q_hit_pending), 1);
      check("t4_e5_rt1", 128'(bus.fwd_rt[13:7]), 12);
      tick();
      check("t4_e6_fwd_valid", 128'(bus.fwd_valid), 128'h04);
      check("t4_e6_q_data", bus.q_data, 128'hBEEF);
      drain();

      // flush with entries at stages 0, 1, 4 and a concurrent issue
      drive(1'b1, 1'b1, 7'd20, 128'hA0, 3'd7, 0, 1'b1);
      tick();
      idle();
      tick();
      tick();
      drive(1'b1, 1'b1, 7'd21, 128'hB0, 3'd7, 0, 1'b1);
      tick();
      drive(1'b1, 1'b1, 7'd22, 128'hC0, 3'd7, 0, 1'b0);
      tick();
      bus.flush = 1'b1;
      drive(1'b1, 1'b1, 7'd23, 128'hD0, 3'd7, 0, 1'b1);
      tick();
      bus.flush = 1'b0;
      idle();
      set_q(7'd22);
      check("t5_flushed_c", 128'(bus.q_hit_pending), 0);
      set_q(7'd23);
      check("t5_flushed_issue", 128'(bus.q_hit_pending), 0);
      set_q(7'd21);
      check("t5_shifted_b", 128'(bus.q_hit_pending), 1);
      set_q(7'd20);
      check("t5_old_a", 128'(bus.q_hit_pending), 1);
      check("t5_old_a_stage5", 128'(bus.fwd_rt[41:35]), 20);
      drain();

      // stall + flush: stage 4 holds, stages 0/1 clear
      drive(1'b1, 1'b1, 7'd30, 128'hE0, 3'd7, 1, 1'b1);
      tick();
      idle();
      tick();
      tick();
      drive(1'b1, 1'b1, 7'd31, 128'hF0, 3'd7, 0, 1'b0);
      tick();
      drive(1'b1, 1'b1, 7'd32, 128'hF1, 3'd7, 0, 1'b0);
      tick();
      bus.stall = 1'b1;
      bus.flush = 1'b1;
      idle();
      tick();
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      check("t5s_stage4_hold", 128'(bus.fwd_rt[34:28]), 30);
      set_q(7'd30);
      check("t5s_e_pending", 128'(bus.q_hit_pending), 1);
      set_q(7'd31);
      check("t5s_f_gone", 128'(bus.q_hit_pending), 0);
      set_q(7'd32);
      check("t5s_g_gone", 128'(bus.q_hit_pending), 0);
      drain();

      // clamps: latency 0 acts as 1; non-writing entry is invisible
      set_q(7'd40);
      drive(1'b1, 1'b1, 7'd40, 128'h40, 3'd0, 0, 1'b1);
      tick();
      check("t6_lat0_fwd_valid", 128'(bus.fwd_valid), 128'h01);
      check("t6_lat0_q_data", bus.q_data, 128'h40);
      drive(1'b1, 1'b0, 7'd50, 128'h50, 3'd1, 0, 1'b1);
      tick();
      idle();
      check("t6_nowe_fwd_valid", 128'(bus.fwd_valid), 128'h02);
      set_q(7'd50);
      check("t6_nowe_ready", 128'(bus.q_hit_ready), 0);
      check("t6_nowe_pending", 128'(bus.q_hit_pending), 0);
      drain();

      // latency 7: ready only at stage 6
      drive(1'b1, 1'b1, 7'd41, 128'h41, 3'd7, 0, 1'b1);
      tick();
      idle();
      for (int k = 1; k <= 7; k++) begin
         check("t6_lat7_fwd_valid", 128'(bus.fwd_valid), (k == 7) ? 128'h40 : 128'h0);
         if (k < 7) tick();
      end
      drain();

      // reset with three entries in flight: nothing may write back
      drive(1'b1, 1'b1, 7'd60, 128'h60, 3'd1, 0, 1'b0);
      tick();
      drive(1'b1, 1'b1, 7'd61, 128'h61, 3'd2, 0, 1'b0);
      tick();
      drive(1'b1, 1'b1, 7'd62, 128'h62, 3'd1, 0, 1'b0);
      tick();
      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      set_q(7'd60);
      check("t7_wb_en", 128'(bus.wb_en), 0);
      check("t7_fwd_valid", 128'(bus.fwd_valid), 0);
      check("t7_q_ready", 128'(bus.q_hit_ready), 0);
      check("t7_q_data", bus.q_data, 0);
      check("t7_fwd_rt", 128'(|bus.fwd_rt), 0);
      check("t7_fwd_data", 128'(|bus.fwd_data), 0);
      repeat (10) tick();

      check("exp_q_empty", 128'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
